// File: rtl/ws_core.sv
// Weight-stationary 8x8 convolution core: xmem -> L0 -> skewed systolic MAC array
// -> per-column output FIFO -> psum memory -> accumulate / ReLU stage.
module ws_core #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int row     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [39:0]            inst,
  input  logic [bw*row-1:0]      D_xmem,
  output logic                   ofifo_valid,
  output logic [col*psum_bw-1:0] sfp_out,
  output logic                   l0_ready,
  output logic                   ififo_ready
);
  localparam logic [6:0] FIFO_FULL = 7'd64;

  typedef struct packed {
    logic          ld;
    logic          ex;
    logic [bw-1:0] a;
  } west_t;

  logic       psum_bypass, acc_en, cen_pmem, wen_pmem;
  logic [8:0] a_pmem;
  logic       cen0_xmem, wen0_xmem;
  logic [7:0] a0_xmem;
  logic       ofifo_rd, l0_rd, l0_wr, execute, load;

  assign psum_bypass = inst[39];
  assign acc_en      = inst[38];
  assign cen_pmem    = inst[37];
  assign wen_pmem    = inst[36];
  assign a_pmem      = inst[35:27];
  assign cen0_xmem   = inst[17];
  assign wen0_xmem   = inst[16];
  assign a0_xmem     = inst[15:8];
  assign ofifo_rd    = inst[7];
  assign l0_rd       = inst[4];
  assign l0_wr       = inst[3];
  assign execute     = inst[1];
  assign load        = inst[0];

  logic unused_inst;
  assign unused_inst = ^{inst[26:18], inst[6:5], inst[2]};
  assign ififo_ready = 1'b1;

  // xmem: single-port SRAM, read data appears the cycle after the access
  logic [bw*row-1:0] xmem_mem [256];
  logic [bw*row-1:0] xmem_q;

  always_ff @(posedge clk) begin
    if (!cen0_xmem && !wen0_xmem) xmem_mem[a0_xmem] <= D_xmem;
    if (!cen0_xmem && wen0_xmem)  xmem_q <= xmem_mem[a0_xmem];
  end

  // Handshakes: l0_wr is accepted only while l0_ready=1 (otherwise dropped);
  // ofifo_rd pops only while ofifo_valid=1, so both are plain valid/ready pairs.
  logic [bw*row-1:0] l0_mem [64];
  logic [5:0]        l0_wp_q, l0_rp_q;
  logic [6:0]        l0_cnt_q;
  logic [bw*row-1:0] l0_vec_q;
  logic              l0_ld_q, l0_ex_q;
  logic              l0_push, l0_pop;

  assign l0_push  = l0_wr && (l0_cnt_q != FIFO_FULL);
  assign l0_pop   = l0_rd && (l0_cnt_q != 7'd0);
  assign l0_ready = (l0_cnt_q != FIFO_FULL);

  always_ff @(posedge clk) begin
    if (l0_push) l0_mem[l0_wp_q] <= xmem_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l0_wp_q  <= '0;
      l0_rp_q  <= '0;
      l0_cnt_q <= '0;
      l0_vec_q <= '0;
      l0_ld_q  <= 1'b0;
      l0_ex_q  <= 1'b0;
    end else begin
      if (l0_push) l0_wp_q <= l0_wp_q + 6'd1;
      if (l0_pop) begin
        l0_rp_q  <= l0_rp_q + 6'd1;
        l0_vec_q <= l0_mem[l0_rp_q];
      end
      l0_cnt_q <= l0_cnt_q + {6'd0, l0_push} - {6'd0, l0_pop};
      l0_ld_q  <= load;
      l0_ex_q  <= execute;
    end
  end

  // Row r enters the array r cycles late so psums meet activations on the diagonal
  west_t [row-1:0] row_in;

  for (genvar r = 0; r < row; r++) begin : g_skew
    west_t lane_in;
    assign lane_in = {l0_ld_q, l0_ex_q, l0_vec_q[bw*r +: bw]};
    if (r == 0) begin : g_direct
      assign row_in[r] = lane_in;
    end else begin : g_delay
      west_t sr_q [r];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < r; k++) sr_q[k] <= '0;
        end else begin
          sr_q[0] <= lane_in;
          for (int k = 1; k < r; k++) sr_q[k] <= sr_q[k-1];
        end
      end
      assign row_in[r] = sr_q[r-1];
    end
  end

  west_t [row-1:0][col-1:0]              east_q, west_in;
  logic  [row-1:0][col-1:0][psum_bw-1:0] psum_q, north_in;
  logic  [row-1:0][col-1:0][bw-1:0]      w_q;
  logic  [row-1:0][col-1:0]              wl_q;

  function automatic logic [psum_bw-1:0] mac_term(input logic [bw-1:0] a, input logic [bw-1:0] w);
    logic signed [2*bw:0] a_s, w_s, p;
    a_s = (2*bw+1)'($signed({1'b0, a}));
    w_s = (2*bw+1)'($signed(w));
    p   = a_s * w_s;
    return {{(psum_bw-2*bw-1){p[2*bw]}}, p};
  endfunction

  always_comb begin
    west_in  = '0;
    north_in = '0;
    for (int r = 0; r < row; r++) begin
      west_in[r][0] = row_in[r];
      for (int c = 1; c < col; c++) west_in[r][c] = east_q[r][c-1];
    end
    for (int c = 0; c < col; c++) begin
      for (int r = 1; r < row; r++) north_in[r][c] = psum_q[r-1][c];
    end
  end

  // A capturing tile forwards a bubble east; that only clears tiles still waiting for weights
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      east_q <= '0;
      psum_q <= '0;
      w_q    <= '0;
      wl_q   <= '0;
    end else begin
      for (int r = 0; r < row; r++) begin
        for (int c = 0; c < col; c++) begin
          if (west_in[r][c].ld && !wl_q[r][c]) begin
            w_q[r][c]    <= west_in[r][c].a;
            wl_q[r][c]   <= 1'b1;
            east_q[r][c] <= '0;
          end else begin
            east_q[r][c] <= west_in[r][c];
            if (!west_in[r][c].ld && !west_in[r][c].ex) wl_q[r][c] <= 1'b0;
          end
          if (west_in[r][c].ex)
            psum_q[r][c] <= north_in[r][c] + mac_term(west_in[r][c].a, w_q[r][c]);
        end
      end
    end
  end

  logic unused_edge;
  always_comb begin
    unused_edge = 1'b0;
    for (int r = 0; r < row; r++) unused_edge = unused_edge ^ (^east_q[r][col-1]);
  end

  // Output FIFO: one queue per column, popped together so read pointer is shared
  logic [psum_bw-1:0]       of_mem [col][64];
  logic [col-1:0][5:0]      of_wp_q;
  logic [5:0]               of_rp_q;
  logic [col-1:0][6:0]      of_cnt_q;
  logic [col-1:0]           of_push, of_nonempty;
  logic                     of_pop;
  logic [col*psum_bw-1:0]   of_head;

  always_comb begin
    of_push     = '0;
    of_nonempty = '0;
    of_head     = '0;
    for (int c = 0; c < col; c++) begin
      of_push[c]     = east_q[row-1][c].ex && (of_cnt_q[c] != FIFO_FULL);
      of_nonempty[c] = (of_cnt_q[c] != 7'd0);
      of_head[psum_bw*c +: psum_bw] = of_mem[c][of_rp_q];
    end
  end

  assign ofifo_valid = &of_nonempty;
  assign of_pop      = ofifo_rd && ofifo_valid;

  always_ff @(posedge clk) begin
    for (int c = 0; c < col; c++) begin
      if (of_push[c]) of_mem[c][of_wp_q[c]] <= psum_q[row-1][c];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      of_wp_q  <= '0;
      of_rp_q  <= '0;
      of_cnt_q <= '0;
    end else begin
      if (of_pop) of_rp_q <= of_rp_q + 6'd1;
      for (int c = 0; c < col; c++) begin
        if (of_push[c]) of_wp_q[c] <= of_wp_q[c] + 6'd1;
        of_cnt_q[c] <= of_cnt_q[c] + {6'd0, of_push[c]} - {6'd0, of_pop};
      end
    end
  end

  logic [col*psum_bw-1:0] pmem_mem [512];
  logic [col*psum_bw-1:0] pmem_q;

  always_ff @(posedge clk) begin
    if (!cen_pmem && !wen_pmem) pmem_mem[a_pmem] <= of_head;
    if (!cen_pmem && wen_pmem)  pmem_q <= pmem_mem[a_pmem];
  end

  // Accumulator: first active cycle after an idle one loads instead of adding
  logic [col-1:0][psum_bw-1:0] acc_q, acc_d, relu_d;
  logic                        acc_prev_q, acc_active;
  logic [col*psum_bw-1:0]      sfp_q;

  assign acc_active = acc_en && !psum_bypass;

  always_comb begin
    acc_d  = acc_q;
    relu_d = '0;
    for (int c = 0; c < col; c++) begin
      if (acc_active)
        acc_d[c] = acc_prev_q ? acc_q[c] + pmem_q[psum_bw*c +: psum_bw]
                              : pmem_q[psum_bw*c +: psum_bw];
      relu_d[c] = acc_q[c][psum_bw-1] ? '0 : acc_q[c];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= '0;
      acc_prev_q <= 1'b0;
      sfp_q      <= '0;
    end else begin
      acc_q      <= acc_d;
      acc_prev_q <= acc_active;
      if (!acc_en) sfp_q <= relu_d;
    end
  end

  assign sfp_out = psum_bypass ? of_head : sfp_q;

endmodule

// File: tb/tb_ws_core.sv
// Directed bench for ws_core: reset, xmem/L0 path, weight load + execute,
// multi-kij ordering, L0 full behaviour and pmem accumulate / ReLU.
module tb_ws_core;
  localparam int B_BYP  = 39;
  localparam int B_ACC  = 38;
  localparam int B_PCEN = 37;
  localparam int B_PWEN = 36;
  localparam int B_CEN0 = 17;
  localparam int B_WEN0 = 16;
  localparam int B_OFRD = 7;
  localparam int B_L0RD = 4;
  localparam int B_L0WR = 3;
  localparam int B_EXEC = 1;
  localparam int B_LOAD = 0;
  localparam logic [39:0] IDLE = (40'd1 << 37) | (40'd1 << 36) | (40'd1 << 26) |
                                 (40'd1 << 17) | (40'd1 << 16);

  logic         clk = 1'b0;
  logic         reset;
  logic [39:0]  inst;
  logic [31:0]  D_xmem;
  logic         ofifo_valid;
  logic [127:0] sfp_out;
  logic         l0_ready;
  logic         ififo_ready;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;

  ws_core dut (
    .clk         (clk),
    .reset       (reset),
    .inst        (inst),
    .D_xmem      (D_xmem),
    .ofifo_valid (ofifo_valid),
    .sfp_out     (sfp_out),
    .l0_ready    (l0_ready),
    .ififo_ready (ififo_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic idle(input int n);
    inst = IDLE;
    repeat (n) tick();
  endtask

  task automatic xmem_write(input logic [7:0] addr, input logic [31:0] data);
    inst = IDLE;
    inst[B_CEN0] = 1'b0;
    inst[B_WEN0] = 1'b0;
    inst[15:8]   = addr;
    D_xmem       = data;
    tick();
    inst = IDLE;
  endtask

  task automatic xmem_to_l0(input logic [7:0] addr);
    inst = IDLE;
    inst[B_CEN0] = 1'b0;
    inst[15:8]   = addr;
    tick();
    inst = IDLE;
    inst[B_L0WR] = 1'b1;
    tick();
    inst = IDLE;
  endtask

  task automatic l0_pop(input logic ld, input logic ex);
    inst = IDLE;
    inst[B_L0RD] = 1'b1;
    inst[B_LOAD] = ld;
    inst[B_EXEC] = ex;
    tick();
    inst = IDLE;
  endtask

  task automatic pop_check(input string tag, input logic [127:0] expv,
                           input logic wr_pmem, input logic [8:0] paddr);
    int guard;
    guard = 0;
    inst = IDLE;
    while (!ofifo_valid && guard < 64) begin
      tick();
      guard++;
    end
    check({tag, "_valid"}, 128'(ofifo_valid), 128'd1);
    inst[B_BYP] = 1'b1;
    #1;
    check(tag, sfp_out, expv);
    inst[B_OFRD] = 1'b1;
    if (wr_pmem) begin
      inst[B_PCEN]  = 1'b0;
      inst[B_PWEN]  = 1'b0;
      inst[35:27]   = paddr;
    end
    tick();
    inst = IDLE;
  endtask

  // Reference: column c = sum_r unsigned a[r] * signed w[r][c]
  function automatic logic [127:0] model(input logic [7:0][31:0] wv, input logic [31:0] av);
    logic [127:0] res;
    int s, a, w;
    res = '0;
    for (int c = 0; c < 8; c++) begin
      s = 0;
      for (int r = 0; r < 8; r++) begin
        a = int'(av[4*r +: 4]);
        w = int'(wv[c][4*r +: 4]);
        if (w > 7) w = w - 16;
        s = s + a * w;
      end
      res[16*c +: 16] = 16'(s);
    end
    return res;
  endfunction

  initial begin
    logic [7:0][31:0] wv;
    logic [31:0]      av [36];
    logic [31:0]      tmp;
    logic [127:0]     expv;
    int               vals [18];
    int               outs [3];

    reset  = 1'b1;
    inst   = IDLE;
    D_xmem = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    check("rst_ofifo_valid", 128'(ofifo_valid), 128'd0);
    check("rst_l0_ready", 128'(l0_ready), 128'd1);
    check("rst_ififo_ready", 128'(ififo_ready), 128'd1);
    check("rst_sfp_out", sfp_out, 128'd0);

    // All weights +1, activation 1 in every row: each column sums to 8
    for (int i = 0; i < 9; i++) xmem_write(8'(i), 32'h1111_1111);
    for (int i = 0; i < 9; i++) xmem_to_l0(8'(i));
    for (int i = 0; i < 8; i++) l0_pop(1'b1, 1'b0);
    l0_pop(1'b0, 1'b1);
    pop_check("ones", {8{16'h0008}}, 1'b0, 9'd0);

    // Weights -1, activation 15 everywhere through xmem addr 0x80: 8*15*-1 = -120
    xmem_write(8'h80, 32'hFFFF_FFFF);
    for (int i = 0; i < 9; i++) xmem_to_l0(8'h80);
    idle(4);
    for (int i = 0; i < 8; i++) l0_pop(1'b1, 1'b0);
    l0_pop(1'b0, 1'b1);
    pop_check("neg", {8{16'hFF88}}, 1'b0, 9'd0);

    // Nine kij passes, 36 activation vectors each, fresh weights every pass
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 8; c++) begin
        tmp   = 32'(k * 8 + c + 1);
        wv[c] = tmp * 32'h9E37_79B9;
        xmem_write(8'(c), wv[c]);
      end
      for (int j = 0; j < 36; j++) begin
        tmp   = 32'(k * 36 + j + 7);
        av[j] = tmp * 32'h85EB_CA6B;
        xmem_write(8'(8 + j), av[j]);
        exp_q.push_back(model(wv, av[j]));
      end
      for (int i = 0; i < 44; i++) xmem_to_l0(8'(i));
      for (int i = 0; i < 8; i++) l0_pop(1'b1, 1'b0);
      for (int j = 0; j < 36; j++) l0_pop(1'b0, 1'b1);
      for (int j = 0; j < 36; j++) begin
        expv = exp_q.pop_front();
        pop_check($sformatf("kij%0d_v%0d", k, j), expv, 1'b0, 9'd0);
      end
      idle(2);
    end

    // Row 0 weight +1, row 1 weight -1: column value = lane0 - lane1
    vals = '{5, -3, -4, 1, -2, 2, -3, 1, 1, 5, -3, 1, 1, 1, 1, 1, 0, 0};
    for (int c = 0; c < 8; c++) xmem_write(8'(c), 32'h0000_00F1);
    for (int i = 0; i < 18; i++) begin
      if (vals[i] >= 0) tmp = 32'(vals[i]);
      else              tmp = 32'(-vals[i]) << 4;
      xmem_write(8'(8 + i), tmp);
    end
    for (int i = 0; i < 26; i++) xmem_to_l0(8'(i));
    for (int i = 0; i < 8; i++) l0_pop(1'b1, 1'b0);
    for (int i = 0; i < 18; i++) l0_pop(1'b0, 1'b1);
    for (int i = 0; i < 18; i++)
      pop_check($sformatf("pw%0d", i), {8{16'(vals[i])}}, 1'b1, 9'(i));

    // Output 0 sums to -2 (ReLU 0), output 1 sums to +7; alternate to expose carry-over
    outs = '{1, 0, 1};
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 9; k++) begin
        inst = IDLE;
        inst[B_PCEN]  = 1'b0;
        inst[35:27]   = 9'(9 * outs[n] + k);
        inst[B_ACC]   = (k > 0);
        tick();
      end
      inst = IDLE;
      inst[B_ACC] = 1'b1;
      tick();
      inst = IDLE;
      tick();
      expv = (outs[n] == 1) ? {8{16'h0007}} : 128'd0;
      check($sformatf("acc%0d_out%0d", n, outs[n]), sfp_out, expv);
    end

    // Leave ofifo and L0 partially filled, then reset mid-stream
    l0_pop(1'b0, 1'b1);
    idle(30);
    check("pre_rst_ofifo_valid", 128'(ofifo_valid), 128'd1);
    inst = IDLE;
    inst[B_L0WR] = 1'b1;
    repeat (10) tick();
    inst  = IDLE;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_ofifo_valid", 128'(ofifo_valid), 128'd0);
    check("mid_rst_l0_ready", 128'(l0_ready), 128'd1);
    check("mid_rst_sfp_out", sfp_out, 128'd0);

    // L0 fills on the 64th push; the 65th is dropped so one pop frees a slot
    inst = IDLE;
    inst[B_L0WR] = 1'b1;
    for (int i = 1; i <= 65; i++) begin
      tick();
      if (i == 63) check("l0_ready_63", 128'(l0_ready), 128'd1);
      if (i == 64) check("l0_ready_64", 128'(l0_ready), 128'd0);
      if (i == 65) check("l0_ready_65", 128'(l0_ready), 128'd0);
    end
    l0_pop(1'b0, 1'b0);
    check("l0_ready_after_pop", 128'(l0_ready), 128'd1);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws_core.md
Name: ws_core

Overview:
- Weight-stationary 8x8 convolution core containing:
  - activation/weight SRAM (xmem)
  - L0 input FIFO
  - 8x8 systolic MAC array
  - output FIFO (ofifo)
  - psum SRAM (pmem)
  - special-function/accumulate unit (sfp)
- Driven entirely by a 40-bit per-cycle instruction word from the top-level controller/bench.
- Produces per-kij partial sums, then accumulated and ReLU'd outputs on sfp_out.

Parameters:
- bw, 4, activation/weight bit width
- psum_bw, 16, partial-sum width
- col, 8, array columns (output channels)
- row, 8, array rows (input channels)

Ports:
- clk input 1 single clock, all state on posedge
- reset input 1 asynchronous, active-high
- inst input 40:
  - [39] psum_bypass, [38] acc, [37] CEN_pmem, [36] WEN_pmem, [35:27] A_pmem
  - [26] CEN1_xmem, [25:18] A1_xmem, [17] CEN0_xmem, [16] WEN0_xmem, [15:8] A0_xmem
  - [7] ofifo_rd, [6] ififo_wr, [5] ififo_rd, [4] l0_rd, [3] l0_wr, [2] mode, [1] execute, [0] load
- D_xmem input bw*row (32) xmem write data
- ofifo_valid output 1 ofifo holds at least one complete psum vector
- sfp_out output col*psum_bw (128) bypassed ofifo head or accumulated output
- l0_ready output 1 L0 not full
- ififo_ready output 1 ififo not full (ififo path reserved, stays 1)

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - Clears FIFOs, array registers, weight-loaded flags and accumulator.
  - sfp_out=0, ofifo_valid=0, l0_ready=1, ififo_ready=1.
  - SRAM contents are not reset.
- xmem: 256x32 single-port SRAM, active-low CEN0/WEN0.
  - Write when CEN0=0 and WEN0=0.
  - Read when CEN0=0 and WEN0=1; Q is valid the following cycle.
  - A1/CEN1 port is reserved, no effect.
- L0: 8 lanes x 4 bits, depth 64.
  - l0_wr pushes xmem Q; l0_rd pops one 32-bit row vector into the array west edge.
  - l0_ready deasserts when full; a push while full is dropped.
  - Lane r = bits [4r+3:4r] feeds array row r.
- Array: load/execute flags propagate west→east and north→south one stage per cycle, with data skewed accordingly.
  - Load: 8 consecutive vectors; vector t is captured as the weights of column t (first-seen stays, later ones pass east).
  - A cycle with load=0 and execute=0 reaching a tile clears its loaded flag, so the next load overwrites weights.
  - Execute: activations are unsigned 4-bit, weights signed 4-bit. Column c psum = sum over r of a[r]*w[r][c], signed, psum_bw wide, no saturation.
  - mode is reserved; only mode=0 (weight-stationary) is required.
- ofifo: depth 64, one entry per column per activation vector.
  - ofifo_valid=1 when every column queue is non-empty.
  - Head vector: column c occupies bits [16c+15:16c].
  - ofifo_rd pops only when valid.
  - Vectors leave in activation order: exactly N outputs for N execute vectors.
- pmem: 512x128 SRAM, active-low CEN/WEN.
  - Write data is the ofifo head, written in the same cycle as ofifo_rd.
  - Read Q is valid the following cycle.
- sfp:
  - psum_bypass=1: sfp_out = ofifo head, combinational.
  - psum_bypass=0 and acc=1: the per-column accumulator adds pmem Q. The first acc cycle after an acc=0 cycle loads Q instead of adding.
  - acc=0: the accumulator holds, and sfp_out is a registered per-column ReLU of the accumulator (negative → 0).
  - Controller convention: acc for pmem read data arrives one cycle after that read's address.

Test Plan:
- Reset mid-stream with L0/ofifo partially filled → ofifo_valid=0, l0_ready=1, sfp_out=0 next cycle.
- Write 0xFFFFFFFF to xmem addr 0x80, read back via l0_wr, then l0_rd → row vector 0xFFFFFFFF at array input one cycle after read.
- Load weights: column c weights all 1, row weights 1 for all r; execute activation 0x11111111 → sfp_out (bypass) each column = 8 (0x0008).
  - Same test with weight 0xF (−1) and activation 0xFFFFFFFF → each column = −120 (0xFF88).
- 36 execute vectors per kij over 9 kij with idle cycle between → 324 vectors leave ofifo in order; weights correctly reloaded per kij.
- Push L0 64 times without reads → l0_ready=0 on the 64th; 65th push is ignored.
- Accumulate 9 pmem words per output: column 0 values 5,−3,…, total −2 → sfp_out column 0 = 0. Total +7 → 7. Adjacent outputs do not carry over.
